// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder.
//   state_e          : responder FSM states (INIT = clear sweep, READY = serving)
//   WORD_BYTES       : bytes per 32-bit word
//   MAX_READ_LATENCY : deepest read pipeline supported by read_pipe
//   word_index()     : byte address -> word index
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int WORD_BYTES       = 4;
  localparam int MAX_READ_LATENCY = 4;

  // The low two address bits select a byte inside the word and are dropped.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return 30'(byte_addr / 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/sram_responder_read_pipe.sv
// read_pipe: fixed-depth valid/data delay line for read responses.
//   clk_i, rst_ni : clock, asynchronous active-low clear of valid and data
//   en_i          : when low every stage holds
//   valid_i/data_i: response entering the line (sampled word)
//   valid_o/data_o: response leaving the line LATENCY enabled cycles later
// A stage only loads data when the stage before it holds a valid response,
// so data_o keeps the last delivered word while valid_o is low.
module read_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else if (en_i) begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/sram_responder.sv
// sram_responder: Avalon-MM slave in front of a word-organised SRAM.
//   clk, reset (async, active-low), clk_en (global hold)
//   chip_select, address (byte), read, write, write_data, byte_enable : request
//   read_data, readdatavalid : pipelined read response
//   waitrequest : request not accepted this cycle
//   init_done   : clear sweep finished, slave serving requests
//   protocol_err, range_err : sticky error flags, cleared only by reset
// Handshake: a request is accepted in a cycle where waitrequest is low and
// chip_select is high with exactly one of read/write high. waitrequest is low
// only in READY with clk_en high. Each accepted read produces exactly one
// readdatavalid pulse READ_LATENCY enabled cycles later, in request order.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  chip_select,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [3:0]            byte_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  init_done,
  output logic                  protocol_err,
  output logic                  range_err
);

  localparam int IW  = $clog2(DEPTH);
  localparam int LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                       (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  state_e          state_q, state_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic            prot_q, range_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [29:0]     idx;
  logic            in_range;
  logic [IW-1:0]   widx;
  logic            req_ok, rd_acc, wr_acc, both_req, sweep_we;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx      = word_index(32'(address));
  assign in_range = idx < 30'(DEPTH);
  assign widx     = idx[IW-1:0];

  assign req_ok   = (state_q == ST_READY) && clk_en && chip_select;
  assign rd_acc   = req_ok && read && !write;
  assign wr_acc   = req_ok && write && !read;
  assign both_req = req_ok && read && write;
  assign sweep_we = (state_q == ST_INIT) && clk_en && (CLEAR_ON_RESET != 0);

  // Out-of-range reads are still answered, with zero data.
  assign rd_word = in_range ? mem[widx] : '0;

  // FSM state and sweep counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        if (clk_en) begin
          if (CLEAR_ON_RESET != 0) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == IW'(DEPTH - 1)) state_d = ST_READY;
          end else begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // Memory array: not reset, so a reset never disturbs stored contents.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_q] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) mem[widx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prot_q  <= 1'b0;
      range_q <= 1'b0;
    end else begin
      if (both_req) prot_q <= 1'b1;
      if ((rd_acc || wr_acc) && !in_range) range_q <= 1'b1;
    end
  end

  read_pipe #(
    .LATENCY (LAT),
    .WIDTH   (DATA_WIDTH)
  ) u_read_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (clk_en),
    .valid_i (rd_acc),
    .data_i  (rd_word),
    .valid_o (readdatavalid),
    .data_o  (read_data)
  );

  assign waitrequest  = (state_q != ST_READY) || !clk_en;
  assign init_done    = (state_q == ST_READY);
  assign protocol_err = prot_q;
  assign range_err    = range_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Avalon-MM slave (responder) in front of a word-organised on-chip SRAM.
- Serves the accelerator's Avalon-MM master: operand matrices, size words and product/result storage.
- Pipelined reads with fixed, parameterised latency; single-cycle writes with byte enables.
- Optional post-reset clear sweep, and sticky error flags for protocol and range violations.

Parameters:
- ADDR_WIDTH, 14, byte-address width on the bus.
- DATA_WIDTH, 32, data width; must be 32 (4 byte lanes).
- DEPTH, 4096, number of 32-bit words implemented; DEPTH <= 2**(ADDR_WIDTH-2).
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1 the memory is zero-filled after reset release.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; low freezes all state, including the pipeline and the sweep.
- chip_select  in  1  slave selected; read and write are ignored when low.
- address  in  ADDR_WIDTH  byte address; word index = address[ADDR_WIDTH-1:2]; bits [1:0] ignored.
- read  in  1  read request.
- write  in  1  write request.
- write_data  in  32  write data.
- byte_enable  in  4  lane enables; bit n writes write_data[8n+7:8n].
- read_data  out  32  read response data.
- readdatavalid  out  1  read_data valid this cycle.
- waitrequest  out  1  request not accepted this cycle.
- init_done  out  1  clear sweep complete; slave ready.
- protocol_err  out  1  sticky: read and write asserted together.
- range_err  out  1  sticky: access to word index >= DEPTH.

Behaviour:
- States: INIT, READY.
- Reset asserted (asynchronous):
  - state = INIT, sweep counter = 0.
  - read_data = 0, readdatavalid = 0, waitrequest = 1, init_done = 0, protocol_err = 0, range_err = 0.
  - All pipeline valid bits cleared; memory contents are not altered asynchronously.
- INIT:
  - waitrequest = 1.
  - If CLEAR_ON_RESET = 1, one word is zeroed per enabled cycle, index 0..DEPTH-1. After the write to DEPTH-1, go to READY; init_done = 1 from the next cycle.
  - If CLEAR_ON_RESET = 0, go to READY after one enabled cycle.
- READY:
  - waitrequest = !clk_en. A request is accepted when chip_select & (read ^ write) & clk_en.
  - Accepted write: lanes selected by byte_enable are updated at the end of that cycle. byte_enable = 0 is a legal no-op.
  - Accepted read:
    - The word is sampled in the acceptance cycle and delivered READ_LATENCY enabled cycles later, with readdatavalid high for exactly 1 cycle.
    - Back-to-back reads sustain one per cycle; responses return in request order.
  - Read-after-write: a read accepted in the cycle after a write returns the new data. A read and a write are never accepted in the same cycle.
  - read & write both high with chip_select: neither is performed, protocol_err is set, waitrequest stays 0.
  - Word index >= DEPTH:
    - Write: dropped.
    - Read: still answered, with data 0 at normal latency.
    - range_err is set in both cases.
  - read_data holds its last value while readdatavalid is low.
- clk_en low: pipeline, sweep counter, state and outputs all hold. waitrequest = 1 in both states.
- Error flags are cleared only by reset.
- Reset mid-operation: in-flight reads are discarded (no readdatavalid after release) and the sweep restarts from 0.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum (INIT, READY);
  - WORD_BYTES = 4 and the byte-to-word index function;
  - the MAX_READ_LATENCY = 4 constant.
- Sub-module read_pipe: a READ_LATENCY-deep valid/data delay line with clk_en hold and asynchronous clear. It is instantiated once.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1, DEPTH = 4096 -> waitrequest is 1 for 4096 cycles, init_done rises on cycle 4097, and a read of 0x0FFC returns 0x00000000.
- Write 0xDEADBEEF to 0x0010 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read 0x0010 -> 0xDEADBEAA, with readdatavalid READ_LATENCY cycles after acceptance.
- 8 back-to-back reads of 0x0000..0x001C after writing values 1..8 -> 8 consecutive readdatavalid pulses carrying 1..8 in order. Repeat with READ_LATENCY = 3.
- Toggle clk_en low for 2 cycles in the middle of that burst -> waitrequest is 1, responses stall and then resume, and no data is lost or duplicated.
- read = write = 1 at 0x0020 -> protocol_err = 1, memory unchanged, no readdatavalid. Read of 0x4000-range index >= DEPTH (DEPTH = 1024, address 0x1000) -> data 0 and range_err = 1.
- Assert reset while 2 reads are in flight -> readdatavalid = 0 immediately, none issued after release, and the flags are cleared.
